alu_decode_stage: RTL and testbench

Decode/operand stage directly upstream of the `alu` block. Accepts one RV32I instruction per cycle over a valid/ready handshake and decodes OP, OP-IMM and LUI into `alu_op_t`. Reads operands from the register file, with write-back bypass and x0 forcing. Presents a registered `{a, b, op, rd}` bundle to the ALU and handles backpressure, flush and illegal encodings.

---
 rtl/alu_decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Decode/operand stage ahead of the ALU: decodes RV32I OP, OP-IMM and LUI into
// alu_op_t, reads operands with write-back bypass, and registers the bundle.
package alu_decode_pkg;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int NBIT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [NBIT-1:0] rs1_data,
  input  logic [NBIT-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [NBIT-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_a,
  output logic [NBIT-1:0] out_b,
  output alu_op_t         out_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  if (NBIT != 32) begin : g_nbit_check
    $error("alu_decode_stage supports NBIT == 32 only");
  end

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holding valid keeps its payload stable until then.
  // in_ready depends combinationally on out_ready and flush (no skid buffer).

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [NBIT-1:0] rs1_val;
  logic [NBIT-1:0] rs2_val;
  logic [NBIT-1:0] imm_i;
  logic [NBIT-1:0] shamt_imm;
  logic [NBIT-1:0] shamt_reg;
  logic [NBIT-1:0] dec_a;
  logic [NBIT-1:0] dec_b;
  alu_op_t         dec_op;
  logic [4:0]      dec_rd;
  logic            dec_illegal;
  logic            load;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign rs1_addr  = in_instr[19:15];
  assign rs2_addr  = in_instr[24:20];
  assign imm_i     = {{(NBIT-12){in_instr[31]}}, in_instr[31:20]};
  assign shamt_imm = {{(NBIT-5){1'b0}}, in_instr[24:20]};
  assign shamt_reg = {{(NBIT-5){1'b0}}, rs2_val[4:0]};

  // x0 always reads zero; a same-cycle write-back to the source wins over the file.
  always_comb begin
    rs1_val = rs1_data;
    if (rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_val = rs2_data;
    if (rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) begin
      rs2_val = wb_data;
    end
  end

  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Defaults describe the illegal bundle; each legal path overrides all fields.
  always_comb begin
    dec_illegal = 1'b1;
    dec_op      = ALU_NOP;
    dec_a       = '0;
    dec_b       = '0;
    dec_rd      = 5'd0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO || (funct7 == F7_ALT && funct3 == 3'b101)) begin
          dec_illegal = 1'b0;
          dec_op      = (funct7 == F7_ALT) ? ALU_SRA : f3_to_op(funct3);
          dec_a       = rs1_val;
          dec_b       = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_reg : rs2_val;
          dec_rd      = in_instr[11:7];
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 == F7_ZERO || (funct7 == F7_ALT && funct3 == 3'b101)) begin
            dec_illegal = 1'b0;
            dec_op      = (funct7 == F7_ALT) ? ALU_SRA : f3_to_op(funct3);
            dec_a       = rs1_val;
            dec_b       = shamt_imm;
            dec_rd      = in_instr[11:7];
          end
        end else begin
          dec_illegal = 1'b0;
          dec_op      = f3_to_op(funct3);
          dec_a       = rs1_val;
          dec_b       = imm_i;
          dec_rd      = in_instr[11:7];
        end
      end
      OPC_LUI: begin
        dec_illegal = 1'b0;
        dec_op      = ALU_ADD;
        dec_a       = '0;
        dec_b       = {in_instr[31:12], {(NBIT-20){1'b0}}};
        dec_rd      = in_instr[11:7];
      end
      default: ;
    endcase
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  // Flush only drops valid; payload registers keep their last contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_op      <= ALU_NOP;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_a       <= dec_a;
      out_b       <= dec_b;
      out_op      <= dec_op;
      out_rd      <= dec_rd;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed instructions, expected bundles queued at
// acceptance and compared by a monitor whenever the DUT hands a bundle off.
module tb_alu_decode_stage;
  import alu_decode_pkg::*;

  localparam int NBIT = 32;
  localparam int W    = 1 + 4 + 5 + NBIT + NBIT;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [NBIT-1:0] rs1_data;
  logic [NBIT-1:0] rs2_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [NBIT-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] out_a;
  logic [NBIT-1:0] out_b;
  alu_op_t         out_op;
  logic [4:0]      out_rd;
  logic            out_illegal;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  alu_decode_stage #(.NBIT(NBIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic ill, input alu_op_t op,
                                      input logic [4:0] rd,
                                      input logic [NBIT-1:0] a,
                                      input logic [NBIT-1:0] b);
    return {ill, op, rd, a, b};
  endfunction

  function automatic logic [W-1:0] cur_bundle();
    return {out_illegal, out_op, out_rd, out_a, out_b};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ill=%0b op=%0d rd=%0d a=%h b=%h expected ill=%0b op=%0d rd=%0d a=%h b=%h",
               name, act[W-1], act[W-2 -: 4], act[W-6 -: 5], act[2*NBIT-1 -: NBIT], act[NBIT-1:0],
               exp[W-1], exp[W-2 -: 4], exp[W-6 -: 5], exp[2*NBIT-1 -: NBIT], exp[NBIT-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one instruction from just after a rising edge and keeps it until
  // accepted; the expected bundle is queued in the acceptance cycle.
  task automatic issue(input logic [31:0] instr, input logic [NBIT-1:0] r1,
                       input logic [NBIT-1:0] r2, input logic wbv,
                       input logic [4:0] wbrd, input logic [NBIT-1:0] wbd,
                       input logic [W-1:0] exp);
    bit done = 0;
    in_valid = 1'b1;
    in_instr = instr;
    rs1_data = r1;
    rs2_data = r2;
    wb_valid = wbv;
    wb_rd    = wbrd;
    wb_data  = wbd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: instr %h not accepted within 20 cycles", instr);
    end
    in_valid = 1'b0;
    wb_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle: got op=%0d rd=%0d a=%h b=%h with no expected entry",
                 out_op, out_rd, out_a, out_b);
      end else begin
        check_bundle("bundle", cur_bundle(), exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] e_addi, e_lui;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    e_addi = mk(1'b0, ALU_ADD, 5'd5, 32'h0, 32'hFFFF_FFFF);
    e_lui  = mk(1'b0, ALU_ADD, 5'd7, 32'h0, 32'h1234_5000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bundle("reset_bundle", cur_bundle(), mk(1'b0, ALU_NOP, 5'd0, 32'h0, 32'h0));
    check_bit("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // ADDI x5,x0,-1 with junk on rs1_data: x0 must still read 0
    issue(32'hFFF0_0293, 32'h0000_0055, 32'h0, 1'b0, 5'd0, 32'h0, e_addi);
    // SRAI x1,x2,4
    issue(32'h4041_5093, 32'h8000_0000, 32'h0, 1'b0, 5'd0, 32'h0,
          mk(1'b0, ALU_SRA, 5'd1, 32'h8000_0000, 32'h4));
    // SLL x4,x1,x2 with bypass onto rs1, then with wb_rd=0 (no bypass)
    issue(32'h0020_9233, 32'h11, 32'h23, 1'b1, 5'd1, 32'hDEAD_BEEF,
          mk(1'b0, ALU_SLL, 5'd4, 32'hDEAD_BEEF, 32'h3));
    issue(32'h0020_9233, 32'h11, 32'h23, 1'b1, 5'd0, 32'hDEAD_BEEF,
          mk(1'b0, ALU_SLL, 5'd4, 32'h11, 32'h3));
    // ADD x3,x1,x2 with bypass onto rs2
    issue(32'h0020_81B3, 32'h100, 32'h200, 1'b1, 5'd2, 32'h77,
          mk(1'b0, ALU_ADD, 5'd3, 32'h100, 32'h77));
    // SUB is illegal, LUI follows
    issue(32'h4020_81B3, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
          mk(1'b1, ALU_NOP, 5'd0, 32'h0, 32'h0));
    issue(32'h1234_53B7, 32'hAAAA, 32'hBBBB, 1'b0, 5'd0, 32'h0, e_lui);
    // MUL (funct7 0000001), SLLI with funct7 0100000, LW opcode: all illegal
    issue(32'h0220_81B3, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
          mk(1'b1, ALU_NOP, 5'd0, 32'h0, 32'h0));
    issue(32'h4020_9213, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
          mk(1'b1, ALU_NOP, 5'd0, 32'h0, 32'h0));
    issue(32'h0000_A183, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
          mk(1'b1, ALU_NOP, 5'd0, 32'h0, 32'h0));
    // SLTIU x6,x1,-2048: most negative immediate
    issue(32'h8000_B313, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0,
          mk(1'b0, ALU_SLTU, 5'd6, 32'h1234, 32'hFFFF_F800));
    drain(10);

    // Backpressure: ADDI held for 3 cycles while LUI waits
    out_ready = 1'b0;
    issue(32'hFFF0_0293, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, e_addi);
    fork
      issue(32'h1234_53B7, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, e_lui);
      begin
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check_bit("stall_out_valid", out_valid, 1'b1);
          check_bit("stall_in_ready", in_ready, 1'b0);
          check_bundle("stall_hold", cur_bundle(), e_addi);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check_bit("after_stall_lui_valid", out_valid, 1'b1);
    check_bundle("after_stall_lui", cur_bundle(), e_lui);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("after_stall_empty", out_valid, 1'b0);
    @(posedge clk); #1;

    // Flush while a bundle is held
    out_ready = 1'b0;
    issue(32'hFFF0_0293, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, e_addi);
    flush = 1'b1;
    @(negedge clk);
    check_bit("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_bit("flush_out_valid", out_valid, 1'b0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());

    // Reset while a bundle is held
    @(posedge clk); #1;
    issue(32'h1234_53B7, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, e_lui);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bit("rst_held_out_valid", out_valid, 1'b0);
    check_bundle("rst_held_bundle", cur_bundle(), mk(1'b0, ALU_NOP, 5'd0, 32'h0, 32'h0));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Stage still works after reset
    issue(32'h4041_5093, 32'h8000_0000, 32'h0, 1'b0, 5'd0, 32'h0,
          mk(1'b0, ALU_SRA, 5'd1, 32'h8000_0000, 32'h4));
    drain(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d expected bundles never presented, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
